dmem_access_ctrl: RTL and testbench

//  Sequences data-memory loads/stores for the single-cycle CPU against a variable-latency req/ack memory.

---
 rtl/dmem_access_ctrl_pkg.sv | 19 +
 rtl/dmem_access_ctrl_if.sv | 25 ++
 rtl/dmem_timeout_cnt.sv | 31 +++
 rtl/dmem_access_ctrl.sv | 126 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// State encoding, abort fill value and the access-start qualifier.
package dmem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Each bit of the load data returned when an access is aborted.
   localparam bit DMEM_ERR_FILL = 1'b1;

   // A new access may only start for a decoded ld/st that is not halted.
   function automatic logic access_start(input logic ld, input logic st, input logic hlt);
      return (ld | st) & ~hlt;
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Req/ack data-memory port: the controller is the master, the memory the slave.
// Request fields are held stable by the master until ack.
interface dmem_access_ctrl_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 16
) ();

   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );

endinterface

// File: rtl/dmem_timeout_cnt.sv
// REQ-cycle counter for the access timeout; cleared when a request launches.
// Instantiated by dmem_access_ctrl only when DMEM_TIMEOUT_EN is defined.
module dmem_timeout_cnt #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned    CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Expiry is only meaningful while the FSM is actually waiting in REQ.
   assign expire_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences CPU loads/stores onto a variable-latency req/ack data memory and stalls the core meanwhile.
// Define DMEM_TIMEOUT_EN to abort requests that see no ack within TIMEOUT_CYC REQ cycles.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int unsigned AW          = 16,
   parameter int unsigned DW          = 16,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               ld_i,
   input  logic               st_i,
   input  logic               hlt_i,
   input  logic [AW-1:0]      addr_i,
   input  logic [DW-1:0]      wdata_i,
   output logic               stall_o,
   output logic               rd_vld_o,
   output logic [DW-1:0]      rdata_o,
   output logic               idle_o,
   output logic               mem_err_o,
   dmem_access_ctrl_if.master mem
);

   state_e        state_q;
   logic          req_q;
   logic          we_q;
   logic          rd_vld_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          start;
   logic          expire;

   assign start = access_start(ld_i, st_i, hlt_i);

`ifdef DMEM_TIMEOUT_EN
   logic err_q;

   dmem_timeout_cnt #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    ((state_q == ST_IDLE) && start),
      .en_i     (state_q == ST_REQ),
      .expire_o (expire)
   );

   assign mem_err_o = err_q;
`else
   logic timeout_unused;

   assign timeout_unused = (TIMEOUT_CYC != 0);
   assign expire         = 1'b0;
   assign mem_err_o      = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         rd_vld_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
         err_q    <= 1'b0;
`endif
      end else begin
         rd_vld_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  we_q    <= st_i;
                  req_q   <= 1'b1;
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A real ack always wins over a same-cycle timeout.
               if (mem.ack) begin
                  req_q    <= 1'b0;
                  rd_vld_q <= ~we_q;
                  if (!we_q) begin
                     rdata_q <= mem.rdata;
                  end
                  state_q  <= ST_DONE;
               end else if (expire) begin
                  req_q    <= 1'b0;
                  rd_vld_q <= ~we_q;
                  if (!we_q) begin
                     rdata_q <= {DW{DMEM_ERR_FILL}};
                  end
`ifdef DMEM_TIMEOUT_EN
                  err_q    <= 1'b1;
`endif
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // DONE releases the stall so the instruction retires with its load data.
   assign stall_o   = start & (state_q != ST_DONE);
   assign idle_o    = (state_q == ST_IDLE) & ~req_q;
   assign rd_vld_o  = rd_vld_q;
   assign rdata_o   = rdata_q;

   assign mem.req   = req_q;
   assign mem.we    = we_q;
   assign mem.addr  = addr_q;
   assign mem.wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: table-driven accesses with a scoreboard,
// plus hand-written reset, halt, spurious-ack and timeout sequences.
module tb_dmem_access_ctrl;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld, st, hlt;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          stall, rd_vld, idle, mem_err;
   logic [DW-1:0] rdata;

   dmem_access_ctrl_if #(.AW(AW), .DW(DW)) mem_bus ();

   dmem_access_ctrl #(
      .AW          (AW),
      .DW          (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .ld_i      (ld),
      .st_i      (st),
      .hlt_i     (hlt),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .stall_o   (stall),
      .rd_vld_o  (rd_vld),
      .rdata_o   (rdata),
      .idle_o    (idle),
      .mem_err_o (mem_err),
      .mem       (mem_bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          ld;
      logic          st;
      logic [15:0]   addr;
      logic [15:0]   wdata;
      logic [15:0]   mrdata;
      int            ack_dly;
      logic          exp_we;
      logic          exp_vld;
      logic [15:0]   exp_rdata;
      int            exp_stall;
   } vec_t;

   typedef struct {
      logic        vld;
      logic [15:0] rdata;
      int          stall;
   } exp_t;

   vec_t vecs [6];
   exp_t sb [$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Entered just after a falling edge; leaves just after the falling edge that starts the next IDLE cycle.
   task automatic run_access(input vec_t v);
      exp_t e;
      int   stall_cnt = 0;
      int   req_cyc   = 0;
      bit   done      = 1'b0;
      bit   stable_ok = 1'b1;
      bit   early_vld = 1'b0;
      ld    = v.ld;
      st    = v.st;
      addr  = v.addr;
      wdata = v.wdata;
      sb.push_back('{vld: v.exp_vld, rdata: v.exp_rdata, stall: v.exp_stall});
      for (int c = 0; c < 200 && !done; c++) begin
         #1;
         if (c == 0) check("req_low_at_start", {31'd0, mem_bus.req}, 32'd0);
         if (c == 1) begin
            check("req_rise", {31'd0, mem_bus.req}, 32'd1);
            check("req_we", {31'd0, mem_bus.we}, {31'd0, v.exp_we});
         end
         if (stall) stall_cnt++;
         if (mem_bus.req) begin
            req_cyc++;
            if (mem_bus.addr !== v.addr || mem_bus.wdata !== v.wdata || mem_bus.we !== v.exp_we)
               stable_ok = 1'b0;
            if (req_cyc == v.ack_dly) begin
               mem_bus.ack   = 1'b1;
               mem_bus.rdata = v.mrdata;
            end
         end
         if (!stall) begin
            done = 1'b1;
            e = sb.pop_front();
            check("rd_vld", {31'd0, rd_vld}, {31'd0, e.vld});
            check("rdata", {16'd0, rdata}, {16'd0, e.rdata});
            check("req_low_after_ack", {31'd0, mem_bus.req}, 32'd0);
            check("stall_cycles", stall_cnt, e.stall);
         end else if (rd_vld) begin
            early_vld = 1'b1;
         end
         @(negedge clk);
         mem_bus.ack   = 1'b0;
         mem_bus.rdata = 16'($urandom);
      end
      if (!done) begin
         check("access_completes", 32'd0, 32'd1);
         sb.delete();
      end
      check("req_fields_stable", {31'd0, stable_ok}, 32'd1);
      check("no_early_rd_vld", {31'd0, early_vld}, 32'd0);
      ld = 1'b0;
      st = 1'b0;
      #1;
      check("idle_after_access", {31'd0, idle}, 32'd1);
      check("rd_vld_one_cycle", {31'd0, rd_vld}, 32'd0);
   endtask

   initial begin
      int ncyc;

      vecs[0] = '{ld:1'b1, st:1'b0, addr:16'h0040, wdata:16'h0000, mrdata:16'hBEEF, ack_dly:3,
                  exp_we:1'b0, exp_vld:1'b1, exp_rdata:16'hBEEF, exp_stall:4};
      vecs[1] = '{ld:1'b0, st:1'b1, addr:16'h0010, wdata:16'h1234, mrdata:16'hDEAD, ack_dly:1,
                  exp_we:1'b1, exp_vld:1'b0, exp_rdata:16'hBEEF, exp_stall:2};
      vecs[2] = '{ld:1'b1, st:1'b0, addr:16'h0100, wdata:16'h0000, mrdata:16'h5A5A, ack_dly:1,
                  exp_we:1'b0, exp_vld:1'b1, exp_rdata:16'h5A5A, exp_stall:2};
      vecs[3] = '{ld:1'b0, st:1'b1, addr:16'h0200, wdata:16'hCAFE, mrdata:16'h1111, ack_dly:2,
                  exp_we:1'b1, exp_vld:1'b0, exp_rdata:16'h5A5A, exp_stall:3};
      vecs[4] = '{ld:1'b1, st:1'b1, addr:16'h0300, wdata:16'h0F0F, mrdata:16'hDEAD, ack_dly:1,
                  exp_we:1'b1, exp_vld:1'b0, exp_rdata:16'h5A5A, exp_stall:2};
      vecs[5] = '{ld:1'b1, st:1'b0, addr:16'hFFFF, wdata:16'h0000, mrdata:16'h0001, ack_dly:5,
                  exp_we:1'b0, exp_vld:1'b1, exp_rdata:16'h0001, exp_stall:6};

      rst = 1'b1; ld = 1'b0; st = 1'b0; hlt = 1'b0; addr = '0; wdata = '0;
      mem_bus.ack = 1'b0; mem_bus.rdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_rd_vld", {31'd0, rd_vld}, 32'd0);
      check("rst_rdata", {16'd0, rdata}, 32'd0);
      check("rst_idle", {31'd0, idle}, 32'd1);
      check("rst_mem_err", {31'd0, mem_err}, 32'd0);
      check("rst_req", {31'd0, mem_bus.req}, 32'd0);
      check("rst_we", {31'd0, mem_bus.we}, 32'd0);
      check("rst_addr", {16'd0, mem_bus.addr}, 32'd0);
      check("rst_wdata", {16'd0, mem_bus.wdata}, 32'd0);

      // Spurious ack while idle must not start anything or touch rdata.
      @(negedge clk);
      mem_bus.ack = 1'b1; mem_bus.rdata = 16'h7777;
      @(negedge clk);
      mem_bus.ack = 1'b0;
      #1;
      check("spur_ack_req", {31'd0, mem_bus.req}, 32'd0);
      check("spur_ack_idle", {31'd0, idle}, 32'd1);
      check("spur_ack_rd_vld", {31'd0, rd_vld}, 32'd0);
      check("spur_ack_rdata", {16'd0, rdata}, 32'd0);

      // Table accesses run back-to-back.
      @(negedge clk);
      for (int i = 0; i < 6; i++) run_access(vecs[i]);

      // Halt blocks a new access from IDLE.
      hlt = 1'b1; ld = 1'b1; addr = 16'h0500;
      #1;
      check("hlt_stall", {31'd0, stall}, 32'd0);
      repeat (3) @(negedge clk);
      #1;
      check("hlt_no_req", {31'd0, mem_bus.req}, 32'd0);
      check("hlt_idle", {31'd0, idle}, 32'd1);
      check("hlt_stall_held", {31'd0, stall}, 32'd0);
      hlt = 1'b0; ld = 1'b0;

      // Halt raised mid-REQ: access still completes.
      @(negedge clk);
      ld = 1'b1; addr = 16'h0600;
      @(negedge clk);
      #1;
      check("hltreq_req", {31'd0, mem_bus.req}, 32'd1);
      @(negedge clk);
      hlt = 1'b1;
      #1;
      check("hltreq_stall", {31'd0, stall}, 32'd0);
      check("hltreq_req_held", {31'd0, mem_bus.req}, 32'd1);
      mem_bus.ack = 1'b1; mem_bus.rdata = 16'h4321;
      @(negedge clk);
      mem_bus.ack = 1'b0;
      #1;
      check("hltreq_rd_vld", {31'd0, rd_vld}, 32'd1);
      check("hltreq_rdata", {16'd0, rdata}, 32'h4321);
      check("hltreq_req_low", {31'd0, mem_bus.req}, 32'd0);
      @(negedge clk);
      ld = 1'b0;
      #1;
      check("hltreq_idle", {31'd0, idle}, 32'd1);
      check("hltreq_rd_vld_drop", {31'd0, rd_vld}, 32'd0);
      hlt = 1'b0;

      // Reset during REQ abandons the access; a late ack is ignored.
      @(negedge clk);
      ld = 1'b1; addr = 16'h0700;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; ld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mem_bus.ack = 1'b1; mem_bus.rdata = 16'h9999;
      #1;
      check("rstreq_req", {31'd0, mem_bus.req}, 32'd0);
      check("rstreq_idle", {31'd0, idle}, 32'd1);
      check("rstreq_stall", {31'd0, stall}, 32'd0);
      check("rstreq_addr", {16'd0, mem_bus.addr}, 32'd0);
      check("rstreq_rdata", {16'd0, rdata}, 32'd0);
      @(negedge clk);
      mem_bus.ack = 1'b0;
      #1;
      check("late_ack_rd_vld", {31'd0, rd_vld}, 32'd0);
      check("late_ack_rdata", {16'd0, rdata}, 32'd0);
      check("late_ack_req", {31'd0, mem_bus.req}, 32'd0);
      check("late_ack_idle", {31'd0, idle}, 32'd1);

      // Load that never sees an ack.
      @(negedge clk);
      ld = 1'b1; addr = 16'h0800;
      ncyc = 0;
      #1;
      while (stall && ncyc < 40) begin
         @(negedge clk);
         #1;
         ncyc++;
      end
`ifdef DMEM_TIMEOUT_EN
      check("to_stall_cycles", ncyc, TO + 1);
      check("to_rd_vld", {31'd0, rd_vld}, 32'd1);
      check("to_rdata", {16'd0, rdata}, 32'hFFFF);
      check("to_mem_err", {31'd0, mem_err}, 32'd1);
      check("to_req_low", {31'd0, mem_bus.req}, 32'd0);
      @(negedge clk);
      ld = 1'b0;
      #1;
      check("to_idle", {31'd0, idle}, 32'd1);
      check("to_err_sticky", {31'd0, mem_err}, 32'd1);
`else
      check("wait_stall", {31'd0, stall}, 32'd1);
      check("wait_req", {31'd0, mem_bus.req}, 32'd1);
      check("wait_mem_err", {31'd0, mem_err}, 32'd0);
      mem_bus.ack = 1'b1; mem_bus.rdata = 16'h2468;
      @(negedge clk);
      mem_bus.ack = 1'b0;
      #1;
      check("wait_rd_vld", {31'd0, rd_vld}, 32'd1);
      check("wait_rdata", {16'd0, rdata}, 32'h2468);
      check("wait_stall_released", {31'd0, stall}, 32'd0);
      @(negedge clk);
      ld = 1'b0;
      #1;
      check("wait_idle", {31'd0, idle}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1);
   end

endmodule
